// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared UART constants and FSM state encoding          |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_transmitter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_transmitter_if : byte handshake and serial line bundle      |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface uart_transmitter_if;

    logic [uart_pkg::UART_DATA_BITS-1:0] tx_data;
    logic                                tx_valid;
    logic                                tx_ready;
    logic                                serial;
    logic                                busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  serial,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output serial,
        output busy
    );

endinterface : uart_transmitter_if
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_baud_gen : bit-period counter, pulses on last cycle of a bit|
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    output logic      bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    assign bit_done = (r_cnt_q == CNT_LAST);

    always_comb begin
        w_cnt_d = r_cnt_q + CNT_W'(1);
        if (clear || bit_done) begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_transmitter : valid/ready byte in, 8N/8E UART frame out     |
// | Option   : `UART_TX_PARITY_EN adds an even-parity bit            |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 2
) (
    input wire logic          clk,
    input wire logic          rst,
    uart_transmitter_if.slave tx_if
);

    localparam logic [2:0] LAST_DATA_IDX = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

    uart_state_e               r_state_q;
    uart_state_e               w_state_d;
    logic [UART_DATA_BITS-1:0] r_shift_q;
    logic [UART_DATA_BITS-1:0] w_shift_d;
    logic [2:0]                r_bit_idx_q;
    logic [2:0]                w_bit_idx_d;
    logic                      r_serial_q;
    logic                      w_serial_d;
    logic                      w_bit_done;
    logic                      w_clear;
    logic                      w_accept;
`ifdef UART_TX_PARITY_EN
    logic                      r_parity_q;
    logic                      w_parity_d;
`endif

    assign w_accept       = tx_if.tx_valid && (r_state_q == ST_IDLE);
    assign tx_if.tx_ready = (r_state_q == ST_IDLE);
    assign tx_if.busy     = (r_state_q != ST_IDLE);
    assign tx_if.serial   = r_serial_q;

    // Counter is held at zero while idle so the first bit gets a full period.
    assign w_clear = (r_state_q == ST_IDLE) || (w_state_d != r_state_q);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .bit_done (w_bit_done)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_shift_d   = r_shift_q;
        w_bit_idx_d = r_bit_idx_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d = ST_START;
                    w_shift_d = tx_if.tx_data;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_shift_d   = {1'b0, r_shift_q[UART_DATA_BITS-1:1]};
                    w_bit_idx_d = r_bit_idx_q + 3'd1;
                    if (r_bit_idx_q == LAST_DATA_IDX) begin
`ifdef UART_TX_PARITY_EN
                        w_state_d = ST_PARITY;
`else
                        w_state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_done) begin
                    if (r_bit_idx_q == LAST_STOP_IDX) begin
                        w_state_d   = ST_IDLE;
                        w_bit_idx_d = 3'd0;
                    end else begin
                        w_bit_idx_d = r_bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                w_state_d   = ST_IDLE;
                w_bit_idx_d = 3'd0;
            end
        endcase
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        w_parity_d = r_parity_q;
        if (w_accept) begin
            w_parity_d = ^tx_if.tx_data;
        end
    end
`endif

    // Line level follows the next state so serial changes on the same edge as the state.
    always_comb begin
        w_serial_d = UART_IDLE_LEVEL;
        case (w_state_d)
            ST_START:  w_serial_d = 1'b0;
            ST_DATA:   w_serial_d = w_shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_serial_d = r_parity_q;
`endif
            default:   w_serial_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_shift_q   <= '0;
            r_bit_idx_q <= 3'd0;
            r_serial_q  <= UART_IDLE_LEVEL;
        end else begin
            r_state_q   <= w_state_d;
            r_shift_q   <= w_shift_d;
            r_bit_idx_q <= w_bit_idx_d;
            r_serial_q  <= w_serial_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_q <= 1'b0;
        end else begin
            r_parity_q <= w_parity_d;
        end
    end
`endif

endmodule : uart_transmitter
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_transmitter : directed self-checking bench               |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_uart_transmitter;

    localparam int CPB = 4;
    localparam int SB  = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 10 + SB;
`else
    localparam int NBITS = 9 + SB;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_transmitter_if u_if ();

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (u_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit k of the vector is the k-th bit on the line; unused upper bits are 1.
    function automatic logic [12:0] model_frame(input logic [7:0] b);
        logic [12:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    // Called just after a negedge with the transmitter idle.
    task automatic send(input logic [7:0] b, input bit hold);
        check("ready_before_accept", {7'd0, u_if.tx_ready}, 8'd1);
        u_if.tx_data  = b;
        u_if.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            u_if.tx_valid = 1'b0;
            u_if.tx_data  = ~b;
        end
    endtask

    task automatic expect_frame(input logic [12:0] f, input string tag,
                                input int inject_bit, input logic [7:0] inject_data);
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (k == inject_bit && c == 0) begin
                    u_if.tx_data  = inject_data;
                    u_if.tx_valid = 1'b1;
                end
                check($sformatf("%s_bit%0d_cyc%0d_serial", tag, k, c), {7'd0, u_if.serial}, {7'd0, f[k]});
                check($sformatf("%s_bit%0d_cyc%0d_busy", tag, k, c), {7'd0, u_if.busy}, 8'd1);
            end
        end
        @(negedge clk);
        check($sformatf("%s_idle_serial", tag), {7'd0, u_if.serial}, 8'd1);
        check($sformatf("%s_idle_busy", tag), {7'd0, u_if.busy}, 8'd0);
        check($sformatf("%s_idle_ready", tag), {7'd0, u_if.tx_ready}, 8'd1);
    endtask

    initial begin
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("rst_serial", {7'd0, u_if.serial}, 8'd1);
        check("rst_ready", {7'd0, u_if.tx_ready}, 8'd1);
        check("rst_busy", {7'd0, u_if.busy}, 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_serial", {7'd0, u_if.serial}, 8'd1);
            check("post_rst_busy", {7'd0, u_if.busy}, 8'd0);
        end

        // 0xA5 against hand-written line sequence
        send(8'hA5, 1'b0);
`ifdef UART_TX_PARITY_EN
        expect_frame(13'b1_1101_0010_1010, "a5", -1, 8'h00);
        send(8'h01, 1'b0);
        expect_frame(13'b1_1110_0000_0010, "p01", -1, 8'h00);
`else
        expect_frame(13'b1_1111_0100_1010, "a5", -1, 8'h00);
`endif

        // Back-to-back with valid held high
        send(8'h00, 1'b1);
        u_if.tx_data = 8'hFF;
        expect_frame(model_frame(8'h00), "b2b00", -1, 8'h00);
        send(8'hFF, 1'b0);
        expect_frame(model_frame(8'hFF), "b2bff", -1, 8'h00);

        // New byte offered during data bit 2 must wait for IDLE
        send(8'h55, 1'b0);
        expect_frame(model_frame(8'h55), "busy55", 3, 8'h3C);
        send(8'h3C, 1'b0);
        expect_frame(model_frame(8'h3C), "after3c", -1, 8'h00);

        // Reset during data bit 3 of 0xF0
        send(8'hF0, 1'b0);
        repeat (18) @(negedge clk);
        check("f0_bit3_before_rst", {7'd0, u_if.serial}, 8'd0);
        #1 rst = 1'b1;
        #1;
        check("midrst_serial", {7'd0, u_if.serial}, 8'd1);
        check("midrst_busy", {7'd0, u_if.busy}, 8'd0);
        check("midrst_ready", {7'd0, u_if.tx_ready}, 8'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_midrst_serial", {7'd0, u_if.serial}, 8'd1);
        end
        send(8'h81, 1'b0);
        expect_frame(model_frame(8'h81), "f81", -1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_transmitter
`default_nettype wire
